// File: rtl/clk_time_pkg.sv
// Shared types and defaults for the minutes/hours stage of the digital clock.
package clk_time_pkg;

   localparam int MIN_LIMIT_DEF  = 60;
   localparam int HOUR_LIMIT_DEF = 24;
   localparam int BCD_IN_W       = 7;

   typedef enum logic {ST_RUN, ST_SET} clk_mode_t;

   typedef logic [7:0] bcd2_t;

endpackage

// File: rtl/bin2bcd_2digit.sv
// Combinational binary (0..99) to packed two-digit BCD {tens,units}.
module bin2bcd_2digit
   import clk_time_pkg::*;
(
   input  logic [BCD_IN_W-1:0] val_i,
   output bcd2_t               bcd_o
);

   logic [3:0]          tens;
   logic [BCD_IN_W-1:0] rem;

   // Repeated subtraction of ten; nine steps cover the full 0..99 range.
   always_comb begin
      tens = 4'd0;
      rem  = val_i;
      for (int t = 0; t < 9; t++) begin
         if (rem >= 7'd10) begin
            rem  = rem - 7'd10;
            tens = tens + 4'd1;
         end
      end
   end

   assign bcd_o = {tens, rem[3:0]};

endmodule

// File: rtl/clk_min_hour_counter.sv
// Minutes/hours stage: counts seconds-overflow edges, supports manual set,
// and drives binary plus registered BCD time to the display.
module clk_min_hour_counter
   import clk_time_pkg::*;
#(
   parameter int MIN_LIMIT  = MIN_LIMIT_DEF,
   parameter int HOUR_LIMIT = HOUR_LIMIT_DEF,
   parameter int MW         = 6,
   parameter int HW         = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_sec_ovf,
   input  logic          i_set_mode,
   input  logic          i_inc_min,
   input  logic          i_inc_hour,
   output logic [MW-1:0] o_min,
   output logic [HW-1:0] o_hour,
   output bcd2_t         o_min_bcd,
   output bcd2_t         o_hour_bcd,
   output logic          o_day_ovf,
   output logic          o_set_active
);

   localparam logic [MW-1:0] MIN_MAX  = MW'(MIN_LIMIT - 1);
   localparam logic [HW-1:0] HOUR_MAX = HW'(HOUR_LIMIT - 1);

   clk_mode_t     state_q, state_d;
   logic          sec_ovf_q;
   logic [MW-1:0] min_q, min_d;
   logic [HW-1:0] hour_q, hour_d;
   bcd2_t         min_bcd_q, hour_bcd_q;
   bcd2_t         min_bcd_d, hour_bcd_d;
   logic          day_ovf_q, day_ovf_d;
   logic          set_active_q;
   logic          tick;

   assign tick    = i_sec_ovf & ~sec_ovf_q;
   assign state_d = i_set_mode ? ST_SET : ST_RUN;

   // All decisions use the current state, so a tick arriving with the SET
   // request is still counted in RUN.
   always_comb begin
      min_d     = min_q;
      hour_d    = hour_q;
      day_ovf_d = 1'b0;
      if (state_q == ST_RUN) begin
         if (tick) begin
            if (min_q == MIN_MAX) begin
               min_d = '0;
               if (hour_q == HOUR_MAX) begin
                  hour_d    = '0;
                  day_ovf_d = 1'b1;
               end else begin
                  hour_d = hour_q + 1'b1;
               end
            end else begin
               min_d = min_q + 1'b1;
            end
         end
      end else begin
         if (i_inc_min) begin
            min_d = (min_q == MIN_MAX) ? '0 : min_q + 1'b1;
         end
         if (i_inc_hour) begin
            hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 1'b1;
         end
      end
   end

   // BCD is taken from next-state counts so it lands with the binary update.
   bin2bcd_2digit u_min_bcd (
      .val_i (BCD_IN_W'(min_d)),
      .bcd_o (min_bcd_d)
   );

   bin2bcd_2digit u_hour_bcd (
      .val_i (BCD_IN_W'(hour_d)),
      .bcd_o (hour_bcd_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_RUN;
         sec_ovf_q    <= 1'b0;
         min_q        <= '0;
         hour_q       <= '0;
         min_bcd_q    <= '0;
         hour_bcd_q   <= '0;
         day_ovf_q    <= 1'b0;
         set_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sec_ovf_q    <= i_sec_ovf;
         min_q        <= min_d;
         hour_q       <= hour_d;
         min_bcd_q    <= min_bcd_d;
         hour_bcd_q   <= hour_bcd_d;
         day_ovf_q    <= day_ovf_d;
         set_active_q <= (state_d == ST_SET);
      end
   end

   assign o_min        = min_q;
   assign o_hour       = hour_q;
   assign o_min_bcd    = min_bcd_q;
   assign o_hour_bcd   = hour_bcd_q;
   assign o_day_ovf    = day_ovf_q;
   assign o_set_active = set_active_q;

endmodule

// File: tb/tb_clk_min_hour_counter.sv
// Directed bench for clk_min_hour_counter: counting, rollover, set mode, reset.
module tb_clk_min_hour_counter;
   import clk_time_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_sec_ovf;
   logic       i_set_mode;
   logic       i_inc_min;
   logic       i_inc_hour;
   logic [5:0] o_min;
   logic [4:0] o_hour;
   bcd2_t      o_min_bcd;
   bcd2_t      o_hour_bcd;
   logic       o_day_ovf;
   logic       o_set_active;

   int vectors     = 0;
   int miscompares = 0;

   clk_min_hour_counter dut (
      .clk          (clk),
      .rst          (rst),
      .i_sec_ovf    (i_sec_ovf),
      .i_set_mode   (i_set_mode),
      .i_inc_min    (i_inc_min),
      .i_inc_hour   (i_inc_hour),
      .o_min        (o_min),
      .o_hour       (o_hour),
      .o_min_bcd    (o_min_bcd),
      .o_hour_bcd   (o_hour_bcd),
      .o_day_ovf    (o_day_ovf),
      .o_set_active (o_set_active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_time(input string tag, input logic [7:0] m, input logic [7:0] h);
      chk({tag, "_min"}, 8'(o_min), m);
      chk({tag, "_hour"}, 8'(o_hour), h);
   endtask

   task automatic tick();
      i_sec_ovf = 1'b1;
      @(negedge clk);
      i_sec_ovf = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse(input logic m, input logic h);
      i_inc_min  = m;
      i_inc_hour = h;
      @(negedge clk);
      i_inc_min  = 1'b0;
      i_inc_hour = 1'b0;
   endtask

   task automatic set_mode(input logic v);
      i_set_mode = v;
      @(negedge clk);
   endtask

   initial begin
      int exp_m;
      rst        = 1'b0;
      i_sec_ovf  = 1'b0;
      i_set_mode = 1'b0;
      i_inc_min  = 1'b0;
      i_inc_hour = 1'b0;
      @(negedge clk);
      chk_time("rst", 8'd0, 8'd0);
      chk("rst_min_bcd", o_min_bcd, 8'h00);
      chk("rst_hour_bcd", o_hour_bcd, 8'h00);
      chk("rst_day_ovf", 8'(o_day_ovf), 8'd0);
      chk("rst_set_active", 8'(o_set_active), 8'd0);
      rst = 1'b1;

      // 60 ticks: minutes walk 1..59 then wrap with an hour carry
      for (int i = 1; i <= 60; i++) begin
         tick();
         exp_m = (i == 60) ? 0 : i;
         chk("t1_min", 8'(o_min), 8'(exp_m));
         chk("t1_min_bcd", o_min_bcd, 8'((exp_m / 10) * 16 + (exp_m % 10)));
      end
      chk("t1_hour", 8'(o_hour), 8'd1);
      chk("t1_hour_bcd", o_hour_bcd, 8'h01);

      // Preload 23:59, then one tick in RUN rolls the day
      set_mode(1'b1);
      chk("t2_set_active", 8'(o_set_active), 8'd1);
      repeat (22) pulse(1'b1, 1'b1);
      repeat (37) pulse(1'b1, 1'b0);
      chk_time("t2_preload", 8'd59, 8'd23);
      chk("t2_min_bcd", o_min_bcd, 8'h59);
      chk("t2_hour_bcd", o_hour_bcd, 8'h23);
      chk("t2_hour_wrap_no_ovf", 8'(o_day_ovf), 8'd0);
      set_mode(1'b0);
      chk("t2_run_active", 8'(o_set_active), 8'd0);
      i_sec_ovf = 1'b1;
      @(negedge clk);
      chk_time("t2_roll", 8'd0, 8'd0);
      chk("t2_day_ovf_hi", 8'(o_day_ovf), 8'd1);
      chk("t2_roll_min_bcd", o_min_bcd, 8'h00);
      chk("t2_roll_hour_bcd", o_hour_bcd, 8'h00);
      i_sec_ovf = 1'b0;
      @(negedge clk);
      chk("t2_day_ovf_lo", 8'(o_day_ovf), 8'd0);

      // Held overflow level yields a single increment
      i_sec_ovf = 1'b1;
      repeat (5) @(negedge clk);
      chk_time("t3_held", 8'd1, 8'd0);
      i_sec_ovf = 1'b0;
      @(negedge clk);
      chk_time("t3_after", 8'd1, 8'd0);
      pulse(1'b1, 1'b1);
      chk_time("t3_run_ignores_inc", 8'd1, 8'd0);

      // SET at 10:59: minute wrap has no carry; both incs apply together
      set_mode(1'b1);
      repeat (10) pulse(1'b0, 1'b1);
      repeat (58) pulse(1'b1, 1'b0);
      chk_time("t4_preload", 8'd59, 8'd10);
      pulse(1'b1, 1'b0);
      chk_time("t4_no_carry", 8'd0, 8'd10);
      pulse(1'b1, 1'b1);
      chk_time("t4_both", 8'd1, 8'd11);
      chk("t4_min_bcd", o_min_bcd, 8'h01);
      chk("t4_hour_bcd", o_hour_bcd, 8'h11);

      // Ticks are discarded in SET; counting resumes in RUN
      repeat (10) tick();
      chk_time("t5_set_discard", 8'd1, 8'd11);
      set_mode(1'b0);
      tick();
      chk_time("t5_resume", 8'd2, 8'd11);
      i_sec_ovf  = 1'b1;
      i_set_mode = 1'b1;
      @(negedge clk);
      chk_time("t5_tick_on_set_edge", 8'd3, 8'd11);
      chk("t5_set_active", 8'(o_set_active), 8'd1);
      i_sec_ovf = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of SET at 17:42
      repeat (6) pulse(1'b0, 1'b1);
      repeat (39) pulse(1'b1, 1'b0);
      chk_time("t6_preload", 8'd42, 8'd17);
      chk("t6_min_bcd", o_min_bcd, 8'h42);
      chk("t6_hour_bcd", o_hour_bcd, 8'h17);
      #2 rst = 1'b0;
      #1;
      chk_time("t6_async", 8'd0, 8'd0);
      chk("t6_async_min_bcd", o_min_bcd, 8'h00);
      chk("t6_async_hour_bcd", o_hour_bcd, 8'h00);
      chk("t6_async_set_active", 8'(o_set_active), 8'd0);
      i_set_mode = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk_time("t6_post_reset", 8'd1, 8'd0);
      chk("t6_post_set_active", 8'(o_set_active), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
